// File: rtl/user_obi_demux.sv
// user_obi_demux: OBI address demultiplexer with in-order responses, internal error target and decode-error counter.
module user_obi_demux #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth = 1,
  parameter int unsigned MaxTrans = 2,
  parameter logic [NumPorts-1:0][AddrWidth-1:0] RuleBase = '0,
  parameter logic [NumPorts-1:0][AddrWidth-1:0] RuleMask = '0,
  parameter logic [DataWidth-1:0] ErrData = DataWidth'(32'hBADCAB1E)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                sbr_req_i,
  output logic                                sbr_gnt_o,
  input  logic [AddrWidth-1:0]                sbr_addr_i,
  input  logic                                sbr_we_i,
  input  logic [DataWidth/8-1:0]              sbr_be_i,
  input  logic [DataWidth-1:0]                sbr_wdata_i,
  input  logic [IdWidth-1:0]                  sbr_aid_i,
  output logic                                sbr_rvalid_o,
  output logic [DataWidth-1:0]                sbr_rdata_o,
  output logic                                sbr_err_o,
  output logic [IdWidth-1:0]                  sbr_rid_o,
  output logic [NumPorts-1:0]                 mgr_req_o,
  input  logic [NumPorts-1:0]                 mgr_gnt_i,
  output logic [AddrWidth-1:0]                mgr_addr_o,
  output logic                                mgr_we_o,
  output logic [DataWidth/8-1:0]              mgr_be_o,
  output logic [DataWidth-1:0]                mgr_wdata_o,
  output logic [IdWidth-1:0]                  mgr_aid_o,
  input  logic [NumPorts-1:0]                 mgr_rvalid_i,
  input  logic [NumPorts-1:0]                 mgr_err_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  mgr_rdata_i,
  input  logic [NumPorts-1:0][IdWidth-1:0]    mgr_rid_i,
  output logic                                busy_o,
  output logic [15:0]                         dec_err_cnt_o
);
  localparam int unsigned SW = $clog2(NumPorts + 1);
  localparam logic [SW-1:0] ERR = SW'(NumPorts);
  logic [SW-1:0] sel, sel_q;
  logic [3:0] cnt;
  logic [15:0] dec_q;
  logic stall, acc, err_sel, err_v_q;
  logic [IdWidth-1:0] err_id_q;
  logic [NumPorts:0] gnt_all, rv_all, er_all;
  logic [NumPorts:0][DataWidth-1:0] rd_all;
  logic [NumPorts:0][IdWidth-1:0] id_all;
  always_comb begin
    sel = ERR;
    for (int i = NumPorts - 1; i >= 0; i--)
      if ((sbr_addr_i & RuleMask[i]) == RuleBase[i]) sel = SW'(i);
  end
  assign err_sel = sel == ERR;
  // Switching targets while anything is outstanding would let responses overtake each other.
  assign stall = cnt == 4'(MaxTrans) || (cnt != '0 && sel != sel_q);
  // Index NumPorts is the error target, which grants without waiting.
  assign gnt_all = {sbr_req_i, mgr_gnt_i};
  assign sbr_gnt_o = rst_ni & gnt_all[sel] & ~stall;
  assign acc = sbr_req_i & sbr_gnt_o;
  assign mgr_req_o = (rst_ni && sbr_req_i && !stall && !err_sel) ? NumPorts'(1) << sel : '0;
  assign mgr_addr_o = sbr_addr_i;
  assign mgr_we_o = sbr_we_i;
  assign mgr_be_o = sbr_be_i;
  assign mgr_wdata_o = sbr_wdata_i;
  assign mgr_aid_o = sbr_aid_i;
  // Error grants drain one per cycle, so a single response register keeps pace with them.
  assign rv_all = {err_v_q, mgr_rvalid_i};
  assign er_all = {1'b1, mgr_err_i};
  assign rd_all = {ErrData, mgr_rdata_i};
  assign id_all = {err_id_q, mgr_rid_i};
  assign sbr_rvalid_o = rst_ni & (cnt != '0) & rv_all[sel_q];
  assign sbr_err_o = er_all[sel_q];
  assign sbr_rdata_o = rd_all[sel_q];
  assign sbr_rid_o = id_all[sel_q];
  assign busy_o = rst_ni & (cnt != '0);
  assign dec_err_cnt_o = rst_ni ? dec_q : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
      sel_q <= '0;
      err_v_q <= 1'b0;
      err_id_q <= '0;
      dec_q <= '0;
    end else begin
      cnt <= cnt + 4'(acc) - 4'(sbr_rvalid_o);
      if (acc) sel_q <= sel;
      if (acc) err_id_q <= sbr_aid_i;
      err_v_q <= acc & err_sel;
      if (acc && err_sel && dec_q != 16'hFFFF) dec_q <= dec_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_user_obi_demux.sv
// tb_user_obi_demux: directed self-checking bench for user_obi_demux.
module tb_user_obi_demux;
  logic clk = 0, rst_ni = 0;
  logic sbr_req = 0, sbr_gnt, sbr_we = 0, sbr_rvalid, sbr_err;
  logic [31:0] sbr_addr = 0, sbr_wdata = 0, sbr_rdata;
  logic [3:0] sbr_be = 0;
  logic [0:0] sbr_aid = 0, sbr_rid;
  logic [2:0] mgr_req, mgr_gnt = 0, mgr_rvalid = 0, mgr_err = 0;
  logic [31:0] mgr_addr, mgr_wdata;
  logic mgr_we;
  logic [3:0] mgr_be;
  logic [0:0] mgr_aid;
  logic [2:0][31:0] mgr_rdata = '0;
  logic [2:0][0:0] mgr_rid = '0;
  logic busy;
  logic [15:0] dec_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  user_obi_demux #(
    .NumPorts(3), .AddrWidth(32), .DataWidth(32), .IdWidth(1), .MaxTrans(2),
    .RuleBase({32'h2000_2000, 32'h2000_1000, 32'h2000_0000}),
    .RuleMask({3{32'hFFFF_F000}}),
    .ErrData(32'hBADCAB1E)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .sbr_req_i(sbr_req), .sbr_gnt_o(sbr_gnt), .sbr_addr_i(sbr_addr), .sbr_we_i(sbr_we),
    .sbr_be_i(sbr_be), .sbr_wdata_i(sbr_wdata), .sbr_aid_i(sbr_aid),
    .sbr_rvalid_o(sbr_rvalid), .sbr_rdata_o(sbr_rdata), .sbr_err_o(sbr_err), .sbr_rid_o(sbr_rid),
    .mgr_req_o(mgr_req), .mgr_gnt_i(mgr_gnt), .mgr_addr_o(mgr_addr), .mgr_we_o(mgr_we),
    .mgr_be_o(mgr_be), .mgr_wdata_o(mgr_wdata), .mgr_aid_o(mgr_aid),
    .mgr_rvalid_i(mgr_rvalid), .mgr_err_i(mgr_err), .mgr_rdata_i(mgr_rdata), .mgr_rid_i(mgr_rid),
    .busy_o(busy), .dec_err_cnt_o(dec_cnt)
  );

  task automatic test_reset();
    @(negedge clk);
    rst_ni = 0; sbr_req = 1; sbr_addr = 32'h3000_0000; mgr_gnt = 3'b111;
    @(posedge clk); @(negedge clk); #1;
    checks++; if (sbr_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", sbr_gnt); end
    checks++; if (mgr_req !== 3'b000) begin failures++; $display("FAIL reset_mgr_req got=%b exp=000", mgr_req); end
    checks++; if ({sbr_rvalid, busy} !== 2'b00) begin failures++; $display("FAIL reset_rvalid_busy got=%b exp=00", {sbr_rvalid, busy}); end
    checks++; if (dec_cnt !== 16'h0) begin failures++; $display("FAIL reset_dec got=%h exp=0000", dec_cnt); end
    @(posedge clk); @(negedge clk);
    sbr_req = 0; mgr_gnt = 0; rst_ni = 1;
  endtask

  task automatic test_port_read();
    @(negedge clk);
    sbr_req = 1; sbr_addr = 32'h2000_1004; sbr_we = 0; mgr_gnt = 3'b010; #1;
    checks++; if (mgr_req !== 3'b010) begin failures++; $display("FAIL rd_mgr_req got=%b exp=010", mgr_req); end
    checks++; if (sbr_gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt got=%b exp=1", sbr_gnt); end
    checks++; if (mgr_addr !== 32'h2000_1004) begin failures++; $display("FAIL rd_addr got=%h exp=20001004", mgr_addr); end
    @(posedge clk); @(negedge clk);
    sbr_req = 0; mgr_gnt = 0; #1;
    checks++; if ({busy, sbr_rvalid} !== 2'b10) begin failures++; $display("FAIL rd_wait got=%b exp=10", {busy, sbr_rvalid}); end
    @(posedge clk); @(negedge clk);
    mgr_rvalid = 3'b010; mgr_rdata[1] = 32'h1234; mgr_err = 3'b000; #1;
    checks++; if ({sbr_rvalid, sbr_err, busy} !== 3'b101) begin failures++; $display("FAIL rd_rsp got=%b exp=101", {sbr_rvalid, sbr_err, busy}); end
    checks++; if (sbr_rdata !== 32'h1234) begin failures++; $display("FAIL rd_data got=%h exp=00001234", sbr_rdata); end
    @(posedge clk); @(negedge clk);
    mgr_rvalid = 0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_idle got=%b exp=0", busy); end
  endtask

  task automatic test_err();
    @(negedge clk);
    sbr_req = 1; sbr_addr = 32'h3000_0000; sbr_aid = 1; #1;
    checks++; if ({sbr_gnt, mgr_req} !== 4'b1000) begin failures++; $display("FAIL err_gnt got=%b exp=1000", {sbr_gnt, mgr_req}); end
    @(posedge clk); @(negedge clk);
    sbr_req = 0; sbr_aid = 0; #1;
    checks++; if ({sbr_rvalid, sbr_err, sbr_rid} !== 3'b111) begin failures++; $display("FAIL err_rsp got=%b exp=111", {sbr_rvalid, sbr_err, sbr_rid}); end
    checks++; if (sbr_rdata !== 32'hBADCAB1E) begin failures++; $display("FAIL err_data got=%h exp=badcab1e", sbr_rdata); end
    checks++; if (dec_cnt !== 16'd1) begin failures++; $display("FAIL err_dec got=%h exp=0001", dec_cnt); end
    @(posedge clk); @(negedge clk); #1;
    checks++; if ({sbr_rvalid, busy} !== 2'b00) begin failures++; $display("FAIL err_once got=%b exp=00", {sbr_rvalid, busy}); end
  endtask

  task automatic test_order();
    @(negedge clk);
    sbr_req = 1; sbr_addr = 32'h2000_0010; mgr_gnt = 3'b001; #1;
    checks++; if ({sbr_gnt, mgr_req} !== 4'b1001) begin failures++; $display("FAIL ord_p0 got=%b exp=1001", {sbr_gnt, mgr_req}); end
    @(posedge clk); @(negedge clk);
    sbr_addr = 32'h2000_2000; mgr_gnt = 3'b100; mgr_rvalid = 3'b010; #1;
    checks++; if ({sbr_gnt, mgr_req} !== 4'b0000) begin failures++; $display("FAIL ord_stall got=%b exp=0000", {sbr_gnt, mgr_req}); end
    checks++; if (sbr_rvalid !== 1'b0) begin failures++; $display("FAIL ord_foreign_rv got=%b exp=0", sbr_rvalid); end
    @(posedge clk); @(negedge clk);
    mgr_rvalid = 3'b001; #1;
    checks++; if ({sbr_gnt, sbr_rvalid} !== 2'b01) begin failures++; $display("FAIL ord_p0_rsp got=%b exp=01", {sbr_gnt, sbr_rvalid}); end
    @(posedge clk); @(negedge clk);
    mgr_rvalid = 0; #1;
    checks++; if ({sbr_gnt, mgr_req} !== 4'b1100) begin failures++; $display("FAIL ord_p2 got=%b exp=1100", {sbr_gnt, mgr_req}); end
    @(posedge clk); @(negedge clk);
    sbr_req = 0; mgr_gnt = 0; mgr_rvalid = 3'b100; #1;
    checks++; if (sbr_rvalid !== 1'b1) begin failures++; $display("FAIL ord_p2_rsp got=%b exp=1", sbr_rvalid); end
    @(posedge clk); @(negedge clk);
    mgr_rvalid = 0;
  endtask

  task automatic test_max_trans();
    @(negedge clk);
    sbr_req = 1; sbr_addr = 32'h2000_1000; mgr_gnt = 3'b010; #1;
    checks++; if (sbr_gnt !== 1'b1) begin failures++; $display("FAIL max_g1 got=%b exp=1", sbr_gnt); end
    @(posedge clk); @(negedge clk); #1;
    checks++; if (sbr_gnt !== 1'b1) begin failures++; $display("FAIL max_g2 got=%b exp=1", sbr_gnt); end
    @(posedge clk); @(negedge clk); #1;
    checks++; if ({sbr_gnt, mgr_req} !== 4'b0000) begin failures++; $display("FAIL max_g3 got=%b exp=0000", {sbr_gnt, mgr_req}); end
    @(posedge clk); @(negedge clk);
    mgr_rvalid = 3'b010; #1;
    checks++; if ({sbr_gnt, sbr_rvalid} !== 2'b01) begin failures++; $display("FAIL max_full_rsp got=%b exp=01", {sbr_gnt, sbr_rvalid}); end
    @(posedge clk); @(negedge clk); #1;
    checks++; if ({sbr_gnt, sbr_rvalid} !== 2'b11) begin failures++; $display("FAIL max_simul got=%b exp=11", {sbr_gnt, sbr_rvalid}); end
    @(posedge clk); @(negedge clk);
    mgr_rvalid = 0; #1;
    checks++; if (sbr_gnt !== 1'b1) begin failures++; $display("FAIL max_refill got=%b exp=1", sbr_gnt); end
    @(posedge clk); @(negedge clk); #1;
    checks++; if (sbr_gnt !== 1'b0) begin failures++; $display("FAIL max_full_again got=%b exp=0", sbr_gnt); end
    sbr_req = 0; mgr_gnt = 0; mgr_rvalid = 3'b010;
    @(posedge clk); @(posedge clk); @(negedge clk);
    mgr_rvalid = 0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL max_drain got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sbr_req = 1; sbr_addr = 32'h2000_1000; mgr_gnt = 3'b010;
    @(posedge clk); @(negedge clk);
    sbr_req = 0; mgr_gnt = 0; rst_ni = 0; #1;
    checks++; if ({busy, sbr_gnt} !== 2'b00) begin failures++; $display("FAIL rstmid_busy got=%b exp=00", {busy, sbr_gnt}); end
    @(posedge clk); @(negedge clk);
    rst_ni = 1; mgr_rvalid = 3'b010; #1;
    checks++; if ({sbr_rvalid, busy} !== 2'b00) begin failures++; $display("FAIL rstmid_late_rv got=%b exp=00", {sbr_rvalid, busy}); end
    @(posedge clk); @(negedge clk);
    mgr_rvalid = 0;
  endtask

  task automatic test_saturate();
    @(negedge clk);
    sbr_req = 1; sbr_addr = 32'h3000_0000;
    repeat (65534) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (dec_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", dec_cnt); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    sbr_req = 0; #1;
    checks++; if (dec_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_max got=%h exp=ffff", dec_cnt); end
    rst_ni = 0;
    @(posedge clk); @(negedge clk);
    rst_ni = 1; #1;
    checks++; if (dec_cnt !== 16'h0) begin failures++; $display("FAIL sat_clear got=%h exp=0000", dec_cnt); end
  endtask

  initial begin
    test_reset();
    test_port_read();
    test_err();
    test_order();
    test_max_trans();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
